// File: rtl/lsb_queue_v2_if.sv
// Memory-side request/response bus of the load/store buffer.
// The buffer is the master; the memory controller is the slave.
interface lsb_queue_v2_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_queue_v2.sv
// Program-ordered load/store buffer: speculative non-I/O loads, committed-only
// stores and ROB-head I/O loads, issued one at a time from the queue head.
module lsb_queue_v2 #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TAG_W   = 4,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             alloc_ready,
  input  logic             alloc_en,
  input  logic             alloc_store,
  input  logic [2:0]       alloc_funct3,
  input  logic [31:0]      alloc_base,
  input  logic [31:0]      alloc_imm,
  input  logic [31:0]      alloc_sdata,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_en,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             rob_head_valid,
  input  logic [TAG_W-1:0] rob_head_tag,
  lsb_queue_v2_if.master   mem,
  output logic             cdb_en,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [31:0]        addr_q   [DEPTH], addr_d   [DEPTH];
  logic [31:0]        sdata_q  [DEPTH], sdata_d  [DEPTH];
  logic [2:0]         funct3_q [DEPTH], funct3_d [DEPTH];
  logic [TAG_W-1:0]   tag_q    [DEPTH], tag_d    [DEPTH];
  logic [DEPTH-1:0]   store_q, store_d, io_q, io_d, committed_q, committed_d;

  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]         mem_len_q, mem_len_d;
  logic               cdb_en_q, cdb_en_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [31:0]        cdb_data_q, cdb_data_d;

  logic [PTR_W-1:0]   count, keep;
  logic [IDX_W-1:0]   head_idx, tail_idx, off, idx;
  logic [31:0]        alloc_addr;
  logic               h_store, h_io, h_committed, eligible, run;
  logic [2:0]         h_funct3;
  logic [TAG_W-1:0]   h_tag;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  load_ext = {24'b0, d[7:0]};
      3'b101:  load_ext = {16'b0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {24'b0, d[7:0]};
      2'b01:   store_data = {16'b0, d[15:0]};
      default: store_data = d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    funct3_d    = funct3_q;
    tag_d       = tag_q;
    store_d     = store_q;
    io_d        = io_q;
    committed_d = committed_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_len_d   = mem_len_q;
    mem_wdata_d = mem_wdata_q;
    cdb_en_d    = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    keep        = '0;
    run         = 1'b1;

    count       = tail_q - head_q;
    alloc_ready = (count < PTR_W'(DEPTH)) && !clear;
    head_idx    = head_q[IDX_W-1:0];
    tail_idx    = tail_q[IDX_W-1:0];
    alloc_addr  = alloc_base + alloc_imm;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = IDX_W'(i) - head_idx;
      if (commit_en && ({1'b0, off} < count) && store_q[i] && (tag_q[i] == commit_tag))
        committed_d[i] = 1'b1;
    end

    if (alloc_en && alloc_ready) begin
      addr_d[tail_idx]      = alloc_addr;
      sdata_d[tail_idx]     = alloc_sdata;
      funct3_d[tail_idx]    = alloc_funct3;
      tag_d[tail_idx]       = alloc_tag;
      store_d[tail_idx]     = alloc_store;
      io_d[tail_idx]        = alloc_addr >= IO_BASE;
      committed_d[tail_idx] = 1'b0;
      tail_d                = tail_q + 1'b1;
    end

    h_store     = store_q[head_idx];
    h_io        = io_q[head_idx];
    h_committed = committed_q[head_idx];
    h_funct3    = funct3_q[head_idx];
    h_tag       = tag_q[head_idx];
    eligible    = (count != '0) &&
                  ((!h_store && !h_io) || (h_store && h_committed) ||
                   (!h_store && h_io && rob_head_valid && (rob_head_tag == h_tag)));

    case (state_q)
      IDLE: begin
        if (eligible && !clear) begin
          mem_req_d   = 1'b1;
          mem_we_d    = h_store;
          mem_addr_d  = addr_q[head_idx];
          mem_len_d   = (h_funct3[1:0] == 2'b00) ? 3'd1 : (h_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
          mem_wdata_d = store_data(h_funct3[1:0], sdata_q[head_idx]);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          // A load completing under clear is discarded; the clear drops its slot.
          if (!clear || h_store) head_d = head_q + 1'b1;
          if (!h_store && !clear) begin
            cdb_en_d   = 1'b1;
            cdb_tag_d  = h_tag;
            cdb_data_d = load_ext(h_funct3, mem.mem_rdata);
          end
        end else if (clear && !h_store) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem.mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Committed stores form a head prefix; measure it after this cycle's commit.
    if (clear) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        idx = head_idx + IDX_W'(j);
        if (run && (PTR_W'(j) < count) && committed_d[idx]) keep = keep + 1'b1;
        else run = 1'b0;
      end
      tail_d = head_q + keep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      committed_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_len_q   <= '0;
      mem_wdata_q <= '0;
      cdb_en_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      committed_q <= committed_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_len_q   <= mem_len_d;
      mem_wdata_q <= mem_wdata_d;
      cdb_en_q    <= cdb_en_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
    addr_q   <= addr_d;
    sdata_q  <= sdata_d;
    funct3_q <= funct3_d;
    tag_q    <= tag_d;
    store_q  <= store_d;
    io_q     <= io_d;
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_len   = mem_len_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cdb_en        = cdb_en_q;
  assign cdb_tag       = cdb_tag_q;
  assign cdb_data      = cdb_data_q;
endmodule

// File: tb/tb_lsb_queue_v2.sv
// Self-checking bench for lsb_queue_v2: directed scenarios plus randomized
// traffic checked against a program-order queue model.
module tb_lsb_queue_v2;
  logic        clk = 1'b0;
  logic        rst, clear, alloc_ready, alloc_en, alloc_store;
  logic [2:0]  alloc_funct3;
  logic [31:0] alloc_base, alloc_imm, alloc_sdata;
  logic [3:0]  alloc_tag, commit_tag, rob_head_tag, cdb_tag;
  logic        commit_en, rob_head_valid, cdb_en;
  logic [31:0] cdb_data;

  lsb_queue_v2_if mif();

  lsb_queue_v2 #(.DEPTH(16), .TAG_W(4), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .clear(clear), .alloc_ready(alloc_ready),
    .alloc_en(alloc_en), .alloc_store(alloc_store), .alloc_funct3(alloc_funct3),
    .alloc_base(alloc_base), .alloc_imm(alloc_imm), .alloc_sdata(alloc_sdata),
    .alloc_tag(alloc_tag), .commit_en(commit_en), .commit_tag(commit_tag),
    .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
    .mem(mif), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  tag;
    bit          committed;
    bit          io;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] next_tag;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [2:0] exp_len(input logic [2:0] f3);
    logic [1:0] sz = f3[1:0];
    return 3'(1 << sz);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [63:0] mask = (64'd1 << (8 * int'(exp_len(f3)))) - 64'd1;
    return sd & mask[31:0];
  endfunction

  function automatic logic [31:0] exp_ext(input logic [2:0] f3, input logic [31:0] rd);
    int unsigned u = rd;
    int v;
    case (f3)
      3'd0: begin v = int'(u % 256); if (v > 127) v -= 256; end
      3'd1: begin v = int'(u % 65536); if (v > 32767) v -= 65536; end
      3'd4: v = int'(u % 256);
      3'd5: v = int'(u % 65536);
      default: v = int'(u);
    endcase
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; alloc_en = 1'b0; alloc_store = 1'b0; alloc_funct3 = '0;
    alloc_base = '0; alloc_imm = '0; alloc_sdata = '0; alloc_tag = '0;
    commit_en = 1'b0; commit_tag = '0; rob_head_valid = 1'b0; rob_head_tag = '0;
    mif.mem_done = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    mq.delete();
    next_tag = '0;
  endtask

  task automatic push(input bit st, input logic [2:0] f3, input logic [31:0] base,
                      input logic [31:0] imm, input logic [31:0] sd);
    ent_t e;
    bit acc = (mq.size() < 16) && !clear;
    alloc_en = 1'b1; alloc_store = st; alloc_funct3 = f3; alloc_base = base;
    alloc_imm = imm; alloc_sdata = sd; alloc_tag = next_tag;
    e.store = st; e.f3 = f3; e.addr = base + imm; e.sdata = sd; e.tag = next_tag;
    e.committed = 1'b0; e.io = (e.addr >= 32'h30000);
    tick();
    alloc_en = 1'b0;
    if (acc) begin mq.push_back(e); next_tag = next_tag + 1'b1; end
  endtask

  task automatic model_commit(input logic [3:0] t);
    foreach (mq[i]) if (mq[i].store && mq[i].tag == t) mq[i].committed = 1'b1;
  endtask

  task automatic model_clear();
    int n = 0;
    while (n < mq.size() && mq[n].committed) n++;
    while (mq.size() > n) mq.delete(mq.size() - 1);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mif.mem_req === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Serves the model head: commits / releases it if needed, answers the memory
  // request and checks the request fields and the CDB result.
  task automatic serve_and_check();
    ent_t e = mq[0];
    bit ok;
    logic [31:0] rd = $urandom;
    if (e.store && !e.committed) begin
      commit_en = 1'b1; commit_tag = e.tag; tick(); commit_en = 1'b0;
      model_commit(e.tag);
    end
    if (e.io && !e.store) begin rob_head_valid = 1'b1; rob_head_tag = e.tag; end
    wait_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL serve_req: got %0b, expected 1 (tag %0d)", ok, e.tag); end
    checks++; if (mif.mem_we !== e.store) begin errors++; $display("FAIL serve_we: got %0b, expected %0b", mif.mem_we, e.store); end
    checks++; if (mif.mem_addr !== e.addr) begin errors++; $display("FAIL serve_addr: got %h, expected %h", mif.mem_addr, e.addr); end
    checks++; if (mif.mem_len !== exp_len(e.f3)) begin errors++; $display("FAIL serve_len: got %0d, expected %0d", mif.mem_len, exp_len(e.f3)); end
    if (e.store) begin
      checks++; if (mif.mem_wdata !== exp_wdata(e.f3, e.sdata)) begin errors++; $display("FAIL serve_wdata: got %h, expected %h", mif.mem_wdata, exp_wdata(e.f3, e.sdata)); end
    end
    repeat ($urandom_range(0, 2)) tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== e.addr) begin errors++; $display("FAIL serve_hold: got req %0b addr %h, expected req 1 addr %h", mif.mem_req, mif.mem_addr, e.addr); end
    mif.mem_done = 1'b1; mif.mem_rdata = rd;
    tick();
    mif.mem_done = 1'b0;
    rob_head_valid = 1'b0;
    checks++; if (cdb_en !== !e.store) begin errors++; $display("FAIL serve_cdb_en: got %0b, expected %0b", cdb_en, !e.store); end
    if (!e.store) begin
      checks++; if (cdb_tag !== e.tag) begin errors++; $display("FAIL serve_cdb_tag: got %0d, expected %0d", cdb_tag, e.tag); end
      checks++; if (cdb_data !== exp_ext(e.f3, rd)) begin errors++; $display("FAIL serve_cdb_data: got %h, expected %h", cdb_data, exp_ext(e.f3, rd)); end
    end
    void'(mq.pop_front());
  endtask

  task automatic drain_all();
    bit quiet = 1'b1;
    while (mq.size() > 0) serve_and_check();
    repeat (4) begin tick(); if (mif.mem_req !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL drain_idle: got mem_req 1 after drain, expected 0"); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b, expected 1", alloc_ready); end
    checks++; if ({mif.mem_req, mif.mem_we, mif.mem_len} !== 5'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b, expected 0", {mif.mem_req, mif.mem_we, mif.mem_len}); end
    checks++; if ({mif.mem_addr, mif.mem_wdata} !== 64'b0) begin errors++; $display("FAIL reset_mem_data: got %h, expected 0", {mif.mem_addr, mif.mem_wdata}); end
    checks++; if ({cdb_en, cdb_tag, cdb_data} !== 37'b0) begin errors++; $display("FAIL reset_cdb: got %h, expected 0", {cdb_en, cdb_tag, cdb_data}); end
  endtask

  task automatic test_load_ext();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      logic [2:0] f3 = (k == 0) ? 3'd0 : 3'd4;
      logic [31:0] want = (k == 0) ? 32'hFFFFFFF0 : 32'h000000F0;
      bit ok;
      push(1'b0, f3, 32'h100, 32'hFFFFFFFF, 32'h0);
      wait_req(ok);
      checks++; if (ok !== 1'b1 || mif.mem_addr !== 32'hFF || mif.mem_len !== 3'd1 || mif.mem_we !== 1'b0) begin errors++; $display("FAIL lb_req: got ok %0b addr %h len %0d we %0b, expected 1 ff 1 0", ok, mif.mem_addr, mif.mem_len, mif.mem_we); end
      mif.mem_done = 1'b1; mif.mem_rdata = 32'h000000F0;
      tick();
      mif.mem_done = 1'b0;
      checks++; if (cdb_en !== 1'b1 || cdb_data !== want) begin errors++; $display("FAIL lb_cdb: got en %0b data %h, expected 1 %h", cdb_en, cdb_data, want); end
      tick();
      checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL lb_cdb_pulse: got %0b, expected 0", cdb_en); end
      void'(mq.pop_front());
    end
  endtask

  task automatic test_store_commit();
    bit quiet = 1'b1;
    do_reset();
    next_tag = 4'd3;
    push(1'b1, 3'd2, 32'h200, 32'h4, 32'hDEADBEEF);
    repeat (6) begin if (mif.mem_req !== 1'b0) quiet = 1'b0; tick(); end
    checks++; if (!quiet) begin errors++; $display("FAIL store_wait: got mem_req 1 before commit, expected 0"); end
    serve_and_check();
    drain_all();
  endtask

  task automatic test_io_load();
    bit quiet = 1'b1;
    int lat = 0;
    do_reset();
    next_tag = 4'd5;
    rob_head_valid = 1'b1; rob_head_tag = 4'd4;
    push(1'b0, 3'd2, 32'h30000, 32'h4, 32'h0);
    repeat (6) begin if (mif.mem_req !== 1'b0) quiet = 1'b0; tick(); end
    checks++; if (!quiet) begin errors++; $display("FAIL io_wait: got mem_req 1 with rob head 4, expected 0"); end
    rob_head_tag = 4'd5;
    for (int i = 0; i < 6; i++) begin tick(); lat++; if (mif.mem_req === 1'b1) break; end
    checks++; if (lat < 1 || lat > 2 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL io_latency: got %0d cycles, expected 1..2", lat); end
    serve_and_check();
    drain_all();
  endtask

  task automatic test_clear();
    bit ok;
    // Committed SH in flight survives; the two loads behind it are dropped.
    do_reset();
    push(1'b1, 3'd1, 32'h400, 32'h2, 32'h1234ABCD);
    push(1'b0, 3'd2, 32'h500, 32'h0, 32'h0);
    push(1'b0, 3'd0, 32'h600, 32'h1, 32'h0);
    commit_en = 1'b1; commit_tag = mq[0].tag; tick(); commit_en = 1'b0;
    model_commit(mq[0].tag);
    wait_req(ok);
    clear = 1'b1; #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL clear_alloc_ready: got %0b, expected 0", alloc_ready); end
    tick(); clear = 1'b0;
    model_clear();
    for (int i = 0; i < 14; i++) push(1'b0, 3'd2, 32'h800 + 32'(4 * i), 32'h0, 32'h0);
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL clear_count15: got %0b, expected 1", alloc_ready); end
    push(1'b0, 3'd5, 32'h900, 32'h0, 32'h0);
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL clear_count16: got %0b, expected 0", alloc_ready); end
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin errors++; $display("FAIL clear_store_busy: got req %0b we %0b, expected 1 1", mif.mem_req, mif.mem_we); end
    drain_all();

    // Uncommitted load in flight: its completion is drained with no CDB.
    push(1'b0, 3'd2, 32'hA00, 32'h0, 32'h0);
    push(1'b0, 3'd2, 32'hB00, 32'h0, 32'h0);
    wait_req(ok);
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    repeat (2) tick();
    checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL drain_hold: got %0b, expected 1", mif.mem_req); end
    mif.mem_done = 1'b1; tick(); mif.mem_done = 1'b0;
    checks++; if (cdb_en !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL drain_done: got cdb_en %0b req %0b, expected 0 0", cdb_en, mif.mem_req); end
    drain_all();

    // Completion in the same cycle as clear produces no CDB.
    push(1'b0, 3'd2, 32'hC00, 32'h0, 32'h0);
    wait_req(ok);
    clear = 1'b1; mif.mem_done = 1'b1; tick(); clear = 1'b0; mif.mem_done = 1'b0;
    model_clear();
    checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL clear_cdb: got %0b, expected 0", cdb_en); end
    drain_all();

    // Commit in the clear cycle keeps the store; the load behind is dropped.
    push(1'b1, 3'd0, 32'hD00, 32'h3, 32'h000000A5);
    push(1'b0, 3'd2, 32'hE00, 32'h0, 32'h0);
    clear = 1'b1; commit_en = 1'b1; commit_tag = mq[0].tag;
    tick(); clear = 1'b0; commit_en = 1'b0;
    model_commit(mq[0].tag);
    model_clear();
    checks++; if (mq.size() != 1) begin errors++; $display("FAIL clear_commit_model: got %0d, expected 1", mq.size()); end
    drain_all();
  endtask

  task automatic test_full_wrap();
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) push(1'b0, 3'd2, 32'h1000 + 32'(4 * i), 32'h0, 32'h0);
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b, expected 0", alloc_ready); end
    push(1'b0, 3'd2, 32'h2000, 32'h0, 32'h0);
    wait_req(ok);
    alloc_en = 1'b1; alloc_store = 1'b0; alloc_funct3 = 3'd2; alloc_base = 32'h2100;
    alloc_imm = '0; alloc_tag = next_tag; mif.mem_done = 1'b1; mif.mem_rdata = 32'h55;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_retire_ready: got %0b, expected 0", alloc_ready); end
    tick(); alloc_en = 1'b0; mif.mem_done = 1'b0;
    checks++; if (cdb_en !== 1'b1 || cdb_tag !== mq[0].tag) begin errors++; $display("FAIL full_retire_cdb: got en %0b tag %0d, expected 1 %0d", cdb_en, cdb_tag, mq[0].tag); end
    void'(mq.pop_front());
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_after_retire: got %0b, expected 1", alloc_ready); end
    drain_all();
  endtask

  task automatic test_random();
    logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    do_reset();
    for (int it = 0; it < 120; it++) begin
      if ((mq.size() < 16 && $urandom_range(0, 2) != 0) || mq.size() == 0) begin
        bit st = $urandom_range(0, 2) == 0;
        logic [2:0] f3 = st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
        push(st, f3, 32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 255)) - 32'd128, $urandom);
      end else begin
        serve_and_check();
      end
    end
    drain_all();
  endtask

  task automatic test_rst_busy();
    bit ok;
    do_reset();
    push(1'b0, 3'd2, 32'h3000, 32'h0, 32'h0);
    push(1'b0, 3'd2, 32'h3004, 32'h0, 32'h0);
    wait_req(ok);
    rst = 1'b1; tick(); rst = 1'b0;
    mq.delete();
    checks++; if (mif.mem_req !== 1'b0 || cdb_en !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_busy: got req %0b cdb %0b ready %0b, expected 0 0 1", mif.mem_req, cdb_en, alloc_ready); end
    mif.mem_done = 1'b1; tick(); mif.mem_done = 1'b0;
    checks++; if (cdb_en !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL rst_late_done: got cdb %0b req %0b, expected 0 0", cdb_en, mif.mem_req); end
    push(1'b0, 3'd1, 32'h3100, 32'h2, 32'h0);
    drain_all();
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_ext();
    test_store_commit();
    test_io_load();
    test_clear();
    test_full_wrap();
    test_random();
    test_rst_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
